// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) memory arbiter: IDLE -> ACCESS (LAT cycles) -> RESP, one transaction at a time.
// Tie-break is fixed CPU priority by default; defining ARB_ROUND_ROBIN_EN alternates winners on contention.
module mem_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  gnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;
    localparam logic [1:0] GNT_CPU = 2'b01;
    localparam logic [1:0] GNT_DMA = 2'b10;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic ROUND_ROBIN = 1'b1;
`else
    localparam logic ROUND_ROBIN = 1'b0;
`endif

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [1:0]  last_gnt;
    logic [1:0]  win;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        win = GNT_CPU;
        if (cpu_req && dma_req) begin
            win = (ROUND_ROBIN && (last_gnt == GNT_CPU)) ? GNT_DMA : GNT_CPU;
        end else if (dma_req) begin
            win = GNT_DMA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt       <= 2'b00;
            last_gnt  <= GNT_DMA;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state    <= ACCESS;
                        gnt      <= win;
                        last_gnt <= win;
                        cnt      <= CNT_INIT;
                        we_q     <= win[0] ? cpu_we    : dma_we;
                        addr_q   <= win[0] ? cpu_addr  : dma_addr;
                        wdata_q  <= win[0] ? cpu_wdata : dma_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        if (!we_q) begin
                            if (gnt[0]) cpu_rdata <= mem_rdata;
                            else        dma_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Memory-side signals come straight from the latched request so they hold for the whole access.
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state == RESP) & gnt[0];
    assign dma_ready = (state == RESP) & gnt[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=2 instance for most scenarios, LAT=1 instance for back-to-back timing.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // LAT=2 instance
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, dma_ready, mem_en, mem_we;
    logic [1:0]  gnt;

    // LAT=1 instance
    logic        b_cpu_req = 0;
    logic [31:0] b_cpu_addr = 0, b_mem_rdata = 0;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
    logic        b_cpu_ready, b_dma_ready, b_mem_en, b_mem_we;
    logic [1:0]  b_gnt;

    mem_arbiter #(.LAT(2)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt(gnt)
    );

    mem_arbiter #(.LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(b_cpu_addr), .cpu_wdata(32'd0),
        .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
        .dma_rdata(b_dma_rdata), .dma_ready(b_dma_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .gnt(b_gnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] order [4];
    logic [1:0] exp_order [4];
    int n_rsp;
    int n_dma_rdy;
    int n_cpu_rdy;

    initial begin
        // Reset state, checked while reset is asserted
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst_dma_ready", 32'(dma_ready), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // CPU read 0x100, LAT=2
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_acc1_en", 32'(mem_en), 32'h1);
        chk("rd_acc1_addr", mem_addr, 32'h100);
        chk("rd_acc1_gnt", 32'(gnt), 32'h1);
        chk("rd_acc1_rdy", 32'(cpu_ready), 32'h0);
        tick();
        chk("rd_acc2_en", 32'(mem_en), 32'h1);
        chk("rd_acc2_addr", mem_addr, 32'h100);
        chk("rd_acc2_rdy", 32'(cpu_ready), 32'h0);
        tick();
        chk("rd_resp_rdy", 32'(cpu_ready), 32'h1);
        chk("rd_resp_en", 32'(mem_en), 32'h0);
        chk("rd_resp_gnt", 32'(gnt), 32'h1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        tick();
        chk("rd_idle_rdy", 32'(cpu_ready), 32'h0);
        chk("rd_idle_gnt", 32'(gnt), 32'h0);

        // DMA write 0x200
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h12345678; mem_rdata = 32'hA5A5A5A5;
        n_dma_rdy = 0;
        tick();
        chk("wr_acc1_gnt", 32'(gnt), 32'h2);
        chk("wr_acc1_we", 32'(mem_we), 32'h1);
        chk("wr_acc1_wdata", mem_wdata, 32'h12345678);
        chk("wr_acc1_addr", mem_addr, 32'h200);
        tick();
        chk("wr_acc2_we", 32'(mem_we), 32'h1);
        chk("wr_acc2_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("wr_resp_dma_rdy", 32'(dma_ready), 32'h1);
        chk("wr_resp_cpu_rdy", 32'(cpu_ready), 32'h0);
        chk("wr_resp_we", 32'(mem_we), 32'h0);
        chk("wr_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("wr_dma_rdata", dma_rdata, 32'h0);
        dma_req = 0; dma_we = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dma_ready) n_dma_rdy++;
        end
        chk("wr_no_extra_rdy", 32'(n_dma_rdy), 32'h0);

        // Both requesters held for four transactions
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`else
        exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`endif
        for (int i = 0; i < 4; i++) order[i] = 2'b00;
        cpu_req = 1; cpu_addr = 32'h110; dma_req = 1; dma_addr = 32'h210; mem_rdata = 32'h0BADF00D;
        n_rsp = 0; n_dma_rdy = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (cpu_ready || dma_ready) begin
                if (n_rsp < 4) order[n_rsp] = gnt;
                n_rsp++;
            end
            if (dma_ready) n_dma_rdy++;
        end
        cpu_req = 0; dma_req = 0;
        chk("tie_n_rsp", 32'(n_rsp), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie_dma_rdy_cnt", 32'(n_dma_rdy), 32'd2);
`else
        chk("tie_dma_rdy_cnt", 32'(n_dma_rdy), 32'd0);
`endif
        tick();

        // Reset in 2nd ACCESS cycle of a CPU read
        cpu_req = 1; cpu_addr = 32'h400; mem_rdata = 32'h44444444;
        tick();
        tick();
        chk("ra_acc2_en", 32'(mem_en), 32'h1);
        #2;
        reset = 1; cpu_req = 0;
        #1;
        chk("ra_en_drop", 32'(mem_en), 32'h0);
        chk("ra_gnt_drop", 32'(gnt), 32'h0);
        chk("ra_addr_clr", mem_addr, 32'h0);
        n_cpu_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (cpu_ready) n_cpu_rdy++;
        end
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (cpu_ready) n_cpu_rdy++;
        end
        chk("ra_no_rdy", 32'(n_cpu_rdy), 32'h0);
        chk("ra_rdata_clr", cpu_rdata, 32'h0);
        cpu_req = 1; cpu_addr = 32'h500; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("ra_new_addr", mem_addr, 32'h500);
        tick();
        tick();
        chk("ra_new_rdy", 32'(cpu_ready), 32'h1);
        chk("ra_new_rdata", cpu_rdata, 32'hCAFEF00D);
        cpu_req = 0;
        tick();

        // Request dropped / address changed mid-access
        cpu_req = 1; cpu_addr = 32'h100; mem_rdata = 32'h11112222;
        n_cpu_rdy = 0;
        tick();
        cpu_req = 0; cpu_addr = 32'h300;
        chk("drop_acc1_addr", mem_addr, 32'h100);
        tick();
        chk("drop_acc2_addr", mem_addr, 32'h100);
        chk("drop_acc2_en", 32'(mem_en), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ready) n_cpu_rdy++;
        end
        chk("drop_rdy_once", 32'(n_cpu_rdy), 32'd1);
        chk("drop_rdata", cpu_rdata, 32'h11112222);

        // LAT=1 back-to-back reads: ACCESS, RESP, IDLE repeating
        b_cpu_req = 1; b_cpu_addr = 32'h600; b_mem_rdata = 32'h55AA55AA;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("b2b_en%0d", i), 32'(b_mem_en), (i % 3 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("b2b_rdy%0d", i), 32'(b_cpu_ready), (i % 3 == 2) ? 32'h1 : 32'h0);
        end
        b_cpu_req = 0;
        chk("b2b_rdata", b_cpu_rdata, 32'h55AA55AA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory access cycles per transaction; legal range 1..15.
REQ-002 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Ports cpu_req / cpu_we  input  1 each  CPU transaction request (held until cpu_ready) / write select.
REQ-005 Ports cpu_addr / cpu_wdata  input  32 each  CPU address / write data.
REQ-006 Ports cpu_rdata  output  32, cpu_ready  output  1  CPU read data / one-cycle completion pulse.
REQ-007 Ports dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready  same widths and meanings as the cpu_* ports, for the DMA requester.
REQ-008 Ports mem_en / mem_we  output  1 each  memory enable / write strobe.
REQ-009 Ports mem_addr / mem_wdata  output  32 each  memory address / write data.
REQ-010 Port mem_rdata  input  32  memory read data, valid in the last ACCESS cycle.
REQ-011 Port gnt  output  2  one-hot owner of the memory: bit0 CPU, bit1 DMA; 2'b00 when idle.

Function
REQ-012 FSM states: IDLE, ACCESS, RESP.
REQ-013 IDLE: no request -> stay; any request -> choose a winner (REQ-020/REQ-021) and go to ACCESS.
REQ-014 On the IDLE->ACCESS edge, latch the winner's addr, we and wdata into internal registers; set gnt; load the cycle counter with LAT-1.
REQ-015 ACCESS: mem_en=1; mem_we, mem_addr, mem_wdata driven from the latched registers and stable for all LAT cycles; the counter decrements every cycle.
REQ-016 ACCESS with counter==0: go to RESP; for a read, capture mem_rdata into the winner's rdata register on that edge.
REQ-017 RESP: exactly one cycle; winner's ready=1; mem_en=0; gnt held; next state IDLE; gnt=2'b00 in IDLE.
REQ-018 Latency: request sampled on edge E -> ready high during cycle E+LAT+1; one IDLE cycle between back-to-back transactions.
REQ-019 Writes leave the winner's rdata register unchanged; the loser's rdata and ready are never touched.
REQ-020 Single request in IDLE: grant that requester.
REQ-021 Both requests in IDLE: resolve per Configuration; record the winner in last_gnt.
REQ-022 The requester drops or renews req on the edge where it samples ready; req high in IDLE is always a new transaction.
REQ-023 A request dropped, or changed in addr/wdata, during ACCESS does not abort the access: it completes with the latched values and ready still pulses.
REQ-024 A losing request stays pending, unserviced, and is arbitrated at the next IDLE.

Reset
REQ-025 Reset forces state=IDLE, counter=0, gnt=2'b00, mem_en=0, mem_we=0, cpu_ready=0, dma_ready=0 immediately, without waiting for a clock edge.
REQ-026 Reset also clears mem_addr, mem_wdata, cpu_rdata and dma_rdata to 0 and sets last_gnt=DMA.
REQ-027 Reset during ACCESS aborts the transaction with no ready pulse; after reset release, arbitration restarts from IDLE.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on a tie the requester not in last_gnt wins, so the grant alternates under continuous contention.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: on a tie the CPU always wins; last_gnt is still maintained but not used.

Verification
REQ-030 LAT=2, CPU read addr 0x100, mem_rdata=0xDEADBEEF -> mem_en high 2 cycles with mem_addr=0x100; cpu_ready pulses in cycle 3 after the request edge; cpu_rdata=0xDEADBEEF.
REQ-031 DMA write addr 0x200, data 0x12345678 -> mem_we=1 and mem_wdata=0x12345678 for LAT cycles; gnt=2'b10; dma_ready pulses once; cpu_rdata and dma_rdata unchanged.
REQ-032 Both requests held for 4 transactions, ARB_ROUND_ROBIN_EN defined -> grant order CPU, DMA, CPU, DMA; macro undefined -> CPU four times, and dma_ready never pulses.
REQ-033 Assert reset in the 2nd ACCESS cycle of a CPU read -> mem_en and gnt drop immediately; no cpu_ready pulse; a fresh request after reset release completes normally.
REQ-034 Drop cpu_req and change cpu_addr to 0x300 in the 1st ACCESS cycle of a request to 0x100 -> mem_addr stays 0x100 throughout; cpu_ready pulses once.
REQ-035 LAT=1, back-to-back CPU reads -> ready pulses every 3 cycles, with one idle cycle between transactions.
